// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: detects period starts on a shared timebase, slews the pulse width
// toward a direction-selected target once per period, and drives a registered pulse (1-cycle lag).
module servo_pwm_gen #(
  parameter int STOP_W    = 150_000,
  parameter int CW_W      = 200_000,
  parameter int CCW_W     = 100_000,
  parameter int SLEW_STEP = 25_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] count_in,
  input  logic        motor_reset,
  input  logic        motor_direction,
  output logic        pwm,
  output logic [17:0] pulse_width,
  output logic        period_start
);

  localparam logic [17:0] LP_STOP = 18'(STOP_W);
  localparam logic [17:0] LP_CW   = 18'(CW_W);
  localparam logic [17:0] LP_CCW  = 18'(CCW_W);
  localparam logic [17:0] LP_SLEW = 18'(SLEW_STEP);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [20:0] r_count_prev;
  logic        r_pwm;
  logic        r_start;
  logic [17:0] r_width;

  logic        w_start;
  logic [17:0] w_target;
  logic [17:0] w_width_new;
  logic [17:0] w_width_nxt;
  logic        w_pwm_nxt;

  // A wrap that skips 0 (timebase shortened) still counts as a new period.
  assign w_start  = (count_in == 21'd0) || (count_in < r_count_prev);
  assign w_target = motor_reset ? LP_STOP : (motor_direction ? LP_CW : LP_CCW);

  // Compare before subtracting so the unsigned arithmetic never wraps.
  always_comb begin
    w_width_new = w_target;
    if (LP_SLEW != 18'd0) begin
      if (w_target >= r_width) begin
        if ((w_target - r_width) > LP_SLEW) w_width_new = r_width + LP_SLEW;
      end else if ((r_width - w_target) > LP_SLEW) begin
        w_width_new = r_width - LP_SLEW;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pwm_nxt   = 1'b0;
    w_width_nxt = r_width;
    if (w_start) begin
      // Every state, HIGH included, restarts the period on a start edge.
      w_width_nxt = w_width_new;
      if (w_width_new == 18'd0) begin
        w_state_nxt = S_LOW;
      end else begin
        w_state_nxt = S_HIGH;
        w_pwm_nxt   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_HIGH: begin
          if (count_in >= {3'b000, r_width}) begin
            w_state_nxt = S_LOW;
          end else begin
            w_pwm_nxt = 1'b1;
          end
        end
        S_LOW:   w_state_nxt = S_LOW;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count_prev <= 21'd0;
      r_pwm        <= 1'b0;
      r_start      <= 1'b0;
      r_width      <= LP_STOP;
    end else begin
      r_state      <= w_state_nxt;
      r_count_prev <= count_in;
      r_pwm        <= w_pwm_nxt;
      r_start      <= w_start;
      r_width      <= w_width_nxt;
    end
  end

  assign pwm          = r_pwm;
  assign pulse_width  = r_width;
  assign period_start = r_start;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with scaled widths (stop 150, cw 200, ccw 100, slew 25)
// on a 400-cycle timebase; a second instance has slewing disabled.
module tb_servo_pwm_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] count_in = 21'd0;
  logic        motor_reset = 1'b1;
  logic        motor_direction = 1'b0;
  logic        pwm, ps, pwm0, ps0;
  logic [17:0] pw, pw0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(.STOP_W(150), .CW_W(200), .CCW_W(100), .SLEW_STEP(25)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .motor_reset(motor_reset),
    .motor_direction(motor_direction), .pwm(pwm), .pulse_width(pw), .period_start(ps)
  );

  servo_pwm_gen #(.STOP_W(150), .CW_W(200), .CCW_W(100), .SLEW_STEP(0)) dut0 (
    .clk(clk), .reset(reset), .count_in(count_in), .motor_reset(motor_reset),
    .motor_direction(motor_direction), .pwm(pwm0), .pulse_width(pw0), .period_start(ps0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives count_in = from..to, one value per clock; optionally toggles direction at tog_at.
  task automatic span(input int from, input int to, input int tog_at,
                      output int hi, output int nps, output int pw_first);
    hi = 0; nps = 0; pw_first = 0;
    for (int c = from; c <= to; c++) begin
      if (c == tog_at) motor_direction = ~motor_direction;
      count_in = 21'(c);
      @(posedge clk); #1;
      if (c == from) pw_first = int'(pw);
      hi  += int'(pwm);
      nps += int'(ps);
    end
  endtask

  initial begin
    int hi, nps, pwf;
    int exp_cw[3];
    int exp_ccw[5];
    exp_cw  = '{175, 200, 200};
    exp_ccw = '{175, 150, 125, 100, 100};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_width", int'(pw), 150);
    chk("rst_pstart", int'(ps), 0);
    reset = 1'b0;

    for (int p = 0; p < 3; p++) begin
      span(0, 399, -1, hi, nps, pwf);
      chk($sformatf("stop_hi%0d", p), hi, 150);
      chk($sformatf("stop_width%0d", p), pwf, 150);
      chk($sformatf("stop_pstart%0d", p), nps, 1);
    end

    motor_reset = 1'b0;
    motor_direction = 1'b1;
    for (int p = 0; p < 3; p++) begin
      span(0, 399, -1, hi, nps, pwf);
      chk($sformatf("cw_width%0d", p), pwf, exp_cw[p]);
      chk($sformatf("cw_hi%0d", p), hi, exp_cw[p]);
      if (p == 0) chk("cw_noslew_width", int'(pw0), 200);
    end

    motor_direction = 1'b0;
    for (int p = 0; p < 5; p++) begin
      span(0, 399, -1, hi, nps, pwf);
      chk($sformatf("ccw_width%0d", p), pwf, exp_ccw[p]);
      chk($sformatf("ccw_hi%0d", p), hi, exp_ccw[p]);
      if (p == 0) chk("ccw_noslew_width", int'(pw0), 100);
    end

    span(0, 399, 50, hi, nps, pwf);
    chk("midtoggle_hi", hi, 100);
    chk("midtoggle_width_end", int'(pw), 100);

    span(0, 299, -1, hi, nps, pwf);
    chk("toggle_next_width", pwf, 125);
    chk("toggle_next_hi", hi, 125);
    span(7, 7, -1, hi, nps, pwf);
    chk("wrap_pstart", nps, 1);
    chk("wrap_pwm", hi, 1);
    chk("wrap_width", pwf, 150);
    span(8, 399, -1, hi, nps, pwf);
    chk("wrap_rest_hi", hi, 142);
    chk("wrap_rest_pstart", nps, 0);

    span(0, 99, -1, hi, nps, pwf);
    chk("hrestart_pre_width", pwf, 175);
    chk("hrestart_pre_hi", hi, 100);
    span(5, 5, -1, hi, nps, pwf);
    chk("hrestart_pstart", nps, 1);
    chk("hrestart_pwm", hi, 1);
    chk("hrestart_width", pwf, 200);
    span(6, 399, -1, hi, nps, pwf);
    chk("hrestart_rest_hi", hi, 194);

    span(0, 80, -1, hi, nps, pwf);
    chk("prerst_width", pwf, 200);
    chk("prerst_pwm", int'(pwm), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_width", int'(pw), 150);
    chk("async_rst_pstart", int'(ps), 0);
    span(81, 89, -1, hi, nps, pwf);
    reset = 1'b0;
    span(90, 399, -1, hi, nps, pwf);
    chk("postrst_hi", hi, 0);
    chk("postrst_pstart", nps, 0);
    chk("postrst_width", pwf, 150);
    motor_reset = 1'b1;
    span(0, 0, -1, hi, nps, pwf);
    chk("postrst_start_pstart", nps, 1);
    chk("postrst_start_pwm", hi, 1);
    chk("postrst_start_width", pwf, 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 Parameter STOP_W, default 150_000, SHALL be the stop pulse width in clk cycles.
REQ-002 Parameter CW_W, default 200_000, SHALL be the clockwise pulse width in clk cycles.
REQ-003 Parameter CCW_W, default 100_000, SHALL be the counterclockwise pulse width in clk cycles.
REQ-004 Parameter SLEW_STEP, default 25_000, SHALL be the maximum width change per period; 0 SHALL disable slewing.
REQ-005 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-006 reset  input  1  SHALL be asynchronous and active-high.
REQ-007 count_in  input  21  SHALL be the shared period timebase, 0..1_999_999, wrapping to 0.
REQ-008 motor_reset  input  1  SHALL request the stop width when 1.
REQ-009 motor_direction  input  1  SHALL select clockwise (1) or counterclockwise (0) when motor_reset=0.
REQ-010 pwm  output  1  SHALL be the registered servo pulse.
REQ-011 pulse_width  output  18  SHALL be the width in force for the current period.
REQ-012 period_start  output  1  SHALL be a one-cycle registered pulse marking each detected period start.

Function
REQ-013 Period start SHALL be detected on any clk edge where count_in==0, or where count_in < count_prev (wrap without passing 0); count_prev is count_in registered.
REQ-014 Target width SHALL be computed only at period start: motor_reset ? STOP_W : (motor_direction ? CW_W : CCW_W); input changes mid-period SHALL have no effect until the next start.
REQ-015 At period start, pulse_width SHALL become target if |target - pulse_width| <= SLEW_STEP or SLEW_STEP==0, else pulse_width +/- SLEW_STEP toward target.
REQ-016 Slew arithmetic SHALL use unsigned 18-bit values with no overflow/underflow (compare before subtract).
REQ-017 FSM states SHALL be IDLE, HIGH, LOW.
REQ-018 IDLE: pwm=0; on period start -> HIGH (or LOW if new pulse_width==0).
REQ-019 HIGH: pwm=1; on the edge sampling count_in >= pulse_width -> LOW, pwm<=0.
REQ-020 LOW: pwm=0; on period start -> HIGH with width update per REQ-015.
REQ-021 Period start in HIGH (timebase shortened) SHALL restart the period: stay HIGH, update width, assert period_start.
REQ-022 pwm SHALL be 1 on exactly pulse_width consecutive cycles per full period, lagging count_in by one cycle (edge sampling count_in=0 sets pwm=1).
REQ-023 period_start SHALL assert on the cycle after every period start edge, including in IDLE.
REQ-024 A period start coinciding with a motor_reset/motor_direction change SHALL use the values sampled on that same edge.

Reset
REQ-025 While reset=1: state=IDLE, pwm=0, pulse_width=STOP_W, period_start=0, count_prev=0, immediately (asynchronous).
REQ-026 Reset deasserted mid-period SHALL keep pwm=0 until the next period start; no partial pulse.

Verification
REQ-027 Reset, then motor_reset=1 for 3 periods -> pwm high 150_000 cycles each period, pulse_width=150_000.
REQ-028 From STOP, motor_reset=0, motor_direction=1 -> widths 175_000, 200_000, 200_000 on successive periods.
REQ-029 From CW (200_000), direction=0 -> 175_000, 150_000, 125_000, 100_000, 100_000; with SLEW_STEP=0 -> 100_000 at once.
REQ-030 Toggle motor_direction at count_in=50_000 within a period -> current pulse width unchanged; change applies only from the next period start.
REQ-031 Force count_in from 1_500_000 to 7 (wrap skipping 0) -> period_start pulses once, pwm re-asserts, HIGH lasts until count_in>=pulse_width.
REQ-032 Assert reset at count_in=80_000 while pwm=1, release at 90_000 -> pwm=0 immediately, stays 0 until next count_in==0, pulse_width=150_000.
